// File: rtl/aes256_pkg.sv
// AES-256 shared constants: forward/inverse S-box, Rcon, FSM states, GF(2^8) helpers.
// Latency: n/a (types, tables and pure functions only).
// Backpressure: n/a.
package aes256_pkg;

  // Controller phases: capture inputs, grow the key schedule, run the inverse rounds.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    EXPAND  = 2'd1,
    DECRYPT = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] inv_sbox_tbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return sbox_tbl[idx +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return inv_sbox_tbl[idx +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Rcon for word index i = 8*(idx+1); AES-256 needs seven of them.
  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = 8'h01;
      3'd1:    r = 8'h02;
      3'd2:    r = 8'h04;
      3'd3:    r = 8'h08;
      3'd4:    r = 8'h10;
      3'd5:    r = 8'h20;
      3'd6:    r = 8'h40;
      default: r = 8'h80;
    endcase
    return r;
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; constant multipliers fold down to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes256_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last_round.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module aes256_inv_round
  import aes256_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic         last_round,
  output logic [127:0] result
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // Byte n sits at row n%4, column n/4; inverse shift moves row r right by r columns.
  for (genvar n = 0; n < 16; n++) begin : g_byte
    localparam int row = n % 4;
    localparam int col = n / 4;
    localparam int src = row + 4 * ((col + 4 - row) % 4);
    assign shifted[127-8*n -: 8] = state[127-8*src -: 8];
    assign subbed[127-8*n -: 8]  = inv_sbox(shifted[127-8*n -: 8]);
    assign keyed[127-8*n -: 8]   = subbed[127-8*n -: 8] ^ rkey[127-8*n -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = keyed[127-32*c -: 8];
    assign a1 = keyed[119-32*c -: 8];
    assign a2 = keyed[111-32*c -: 8];
    assign a3 = keyed[103-32*c -: 8];
    assign mixed[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mixed[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mixed[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mixed[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  assign result = last_round ? keyed : mixed;

endmodule

// File: rtl/aes_256.sv
// Iterative free-running AES-256 decryptor (LOAD, 13x EXPAND, 14x DECRYPT); optional key cache via AES256_KEY_CACHE_EN.
// Latency/period: 28 cycles LOAD to plaintext update (15 on a key-cache hit).
// Backpressure: none; inputs sampled only in LOAD, plaintext held until the next result.
module aes_256
  import aes256_pkg::*;
(
  input  logic         enable,
  input  logic         reset,
  input  logic [127:0] ciphertext,
  input  logic [255:0] key,
  output logic [127:0] plaintext
);

  aes_state_e   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] rk_q [15];
  logic [127:0] ct_q;
  logic [127:0] st_q;

  logic [3:0]   exp_hi_idx;
  logic [3:0]   exp_wr_idx;
  logic [3:0]   dec_idx;
  logic [127:0] exp_lo;
  logic [127:0] exp_hi;
  logic [31:0]  temp;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] round_in;
  logic [127:0] round_out;
  logic         last_round;
  logic         cache_hit;

  assign exp_hi_idx = rnd_q + 4'd1;
  assign exp_wr_idx = rnd_q + 4'd2;
  assign dec_idx    = 4'd13 - rnd_q;

  // Next four schedule words from the previous eight; even steps start at i mod 8 = 0.
  always_comb begin
    exp_lo = rk_q[rnd_q];
    exp_hi = rk_q[exp_hi_idx];
    if (!rnd_q[0]) begin
      temp = sub_word({exp_hi[23:0], exp_hi[31:24]}) ^ {rcon(rnd_q[3:1]), 24'h000000};
    end else begin
      temp = sub_word(exp_hi[31:0]);
    end
    w0 = exp_lo[127:96] ^ temp;
    w1 = exp_lo[95:64]  ^ w0;
    w2 = exp_lo[63:32]  ^ w1;
    w3 = exp_lo[31:0]   ^ w2;
  end

  assign round_in   = (rnd_q == 4'd0) ? (ct_q ^ rk_q[14]) : st_q;
  assign last_round = (rnd_q == 4'd13);

  aes256_inv_round u_round (
    .state      (round_in),
    .rkey       (rk_q[dec_idx]),
    .last_round (last_round),
    .result     (round_out)
  );

`ifdef AES256_KEY_CACHE_EN
  logic [255:0] cached_key;
  logic         cache_vld;

  assign cache_hit = cache_vld && (key == cached_key);

  // Remember the key of the last finished schedule; invalidate when a new one starts.
  always_ff @(posedge enable or negedge reset) begin
    if (!reset) begin
      cached_key <= '0;
      cache_vld  <= 1'b0;
    end else if (state_q == LOAD && !cache_hit) begin
      cache_vld  <= 1'b0;
    end else if (state_q == EXPAND && rnd_q == 4'd12) begin
      cached_key <= {rk_q[0], rk_q[1]};
      cache_vld  <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Controller state register.
  always_ff @(posedge enable or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // Phase sequencing and round counting.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    case (state_q)
      LOAD: begin
        state_d = cache_hit ? DECRYPT : EXPAND;
        rnd_d   = 4'd0;
      end
      EXPAND: begin
        if (rnd_q == 4'd12) begin
          state_d = DECRYPT;
          rnd_d   = 4'd0;
        end else begin
          rnd_d   = rnd_q + 4'd1;
        end
      end
      DECRYPT: begin
        if (rnd_q == 4'd13) begin
          state_d = LOAD;
          rnd_d   = 4'd0;
        end else begin
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: begin
        state_d = LOAD;
        rnd_d   = 4'd0;
      end
    endcase
  end

  // Key schedule, working state and result registers.
  always_ff @(posedge enable or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) rk_q[i] <= '0;
      ct_q      <= '0;
      st_q      <= '0;
      plaintext <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          ct_q    <= ciphertext;
          rk_q[0] <= key[255:128];
          rk_q[1] <= key[127:0];
        end
        EXPAND: begin
          rk_q[exp_wr_idx] <= {w0, w1, w2, w3};
        end
        DECRYPT: begin
          st_q <= round_out;
          if (last_round) plaintext <= round_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_256.sv
// Directed bench for aes_256: NIST/FIPS vectors, latency, period, abort-on-reset, input-change isolation.
// Latency checked edge-exact; cache build (AES256_KEY_CACHE_EN) expects the shortened period.
// Backpressure: none to exercise.
module tb_aes_256;

  logic         enable;
  logic         reset;
  logic [127:0] ciphertext;
  logic [255:0] key;
  logic [127:0] plaintext;

  int checks = 0;
  int errors = 0;

`ifdef AES256_KEY_CACHE_EN
  localparam int PER = 15;
  localparam int EXP_CYC = 0;
`else
  localparam int PER = 28;
  localparam int EXP_CYC = 13;
`endif

  localparam logic [255:0] NIST_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    logic [255:0] k;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [5];

  aes_256 dut (
    .enable     (enable),
    .reset      (reset),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext)
  );

  initial enable = 1'b0;
  always #5 enable = ~enable;

  task automatic tick();
    @(posedge enable);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{NIST_KEY, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[1] = '{FIPS_KEY, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{NIST_KEY, 128'h591ccb10d410ed26dc5ba74a31362870, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vecs[3] = '{NIST_KEY, 128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
    vecs[4] = '{NIST_KEY, 128'h23304b7a39f9f3ff067d8d8f9e24ecc7, 128'hf69f2445df4f9b17ad2b417be66c3710};

    reset      = 1'b0;
    key        = '0;
    ciphertext = '0;
    ticks(3);
    check("reset_idle", plaintext, 128'h0);
    key        = vecs[0].k;
    ciphertext = vecs[0].ct;
    ticks(40);
    check("reset_hold", plaintext, 128'h0);

    // Each vector: fresh reset, exact 28-cycle latency.
    for (int i = 0; i < 5; i++) begin
      reset = 1'b0;
      tick();
      key        = vecs[i].k;
      ciphertext = vecs[i].ct;
      check($sformatf("vec%0d_rst", i), plaintext, 128'h0);
      reset = 1'b1;
      ticks(27);
      check($sformatf("vec%0d_early", i), plaintext, 128'h0);
      tick();
      check($sformatf("vec%0d_pt", i), plaintext, vecs[i].pt);
    end

    // Ciphertext changed during EXPAND only affects the next period.
    reset = 1'b0;
    tick();
    key        = vecs[0].k;
    ciphertext = vecs[0].ct;
    reset = 1'b1;
    ticks(3);
    ciphertext = vecs[2].ct;
    ticks(25);
    check("midexp_old", plaintext, vecs[0].pt);
    ticks(PER - 1);
    check("midexp_hold", plaintext, vecs[0].pt);
    tick();
    check("midexp_new", plaintext, vecs[2].pt);

    // Reset during DECRYPT cycle 7 of the following period aborts it.
    ciphertext = vecs[3].ct;
    ticks(1 + EXP_CYC + 6);
    reset = 1'b0;
    #1;
    check("abort_clear", plaintext, 128'h0);
    ticks(3);
    reset = 1'b1;
    ticks(27);
    check("abort_early", plaintext, 128'h0);
    tick();
    check("abort_pt", plaintext, vecs[3].pt);

    // Same key again: shortened period when the cache is built in.
    ciphertext = vecs[4].ct;
    ticks(PER - 1);
    check("samekey_hold", plaintext, vecs[3].pt);
    tick();
    check("samekey_pt", plaintext, vecs[4].pt);

    // New key always pays the full schedule.
    key        = vecs[1].k;
    ciphertext = vecs[1].ct;
    ticks(27);
    check("newkey_hold", plaintext, vecs[4].pt);
    tick();
    check("newkey_pt", plaintext, vecs[1].pt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_256.md
AES_256 -- requirements
Module: aes_256

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose `enable`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL expose `reset`, input, 1 bit: asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL expose `ciphertext`, input, 128 bits: AES block to decrypt; byte 0 is [127:120], column-major state order per FIPS-197.
REQ-005 SHALL expose `key`, input, 256 bits: AES-256 cipher key; byte 0 is [255:248].
REQ-006 SHALL expose `plaintext`, output, 128 bits: registered decryption result, same byte order as `ciphertext`.
REQ-007 SHALL have no parameters; widths fixed at 128/256.

Function
REQ-008 SHALL implement the FIPS-197 AES-256 inverse cipher: 14 rounds, 15 round keys from 60-word key expansion (Nk=8, Rcon, RotWord/SubWord every 8th word, SubWord only at i mod 8 = 4).
REQ-009 SHALL be iterative and free-running, with FSM states LOAD, EXPAND, DECRYPT.
REQ-010 LOAD, 1 cycle: register `ciphertext` and `key`; rk0 = key[255:128], rk1 = key[127:0]; go to EXPAND.
REQ-011 EXPAND, 13 cycles: each cycle derives the next round key (4 words) from the previous 8 words, producing rk2..rk14; then go to DECRYPT.
REQ-012 DECRYPT, 14 cycles:
- Cycle 1 computes state = ct XOR rk14, then one inverse round with rk13.
- Cycle k (k = 1..13) applies InvShiftRows, InvSubBytes, AddRoundKey(rk[14-k]), InvMixColumns.
- Cycle 14 applies InvShiftRows, InvSubBytes, AddRoundKey(rk0), with no InvMixColumns.
REQ-013 At the end of DECRYPT cycle 14, `plaintext` SHALL load the result, then the FSM returns to LOAD.
REQ-014 Latency and period SHALL each be 28 cycles (LOAD to `plaintext` update); `plaintext` is held stable between updates.
REQ-015 Input changes outside LOAD SHALL be ignored until the next LOAD.
REQ-016 All byte arithmetic SHALL be GF(2^8) with polynomial 0x11B; InvMixColumns multipliers are 0e, 0b, 0d, 09.

Reset
REQ-017 While `reset`=0: `plaintext`=128'h0, FSM=LOAD, round counter=0, round-key and state registers cleared.
REQ-018 Reset asserted mid-EXPAND or mid-DECRYPT SHALL abort immediately; after release, operation restarts from LOAD and the aborted result is never output.
REQ-019 After reset release, the first valid `plaintext` SHALL appear 28 cycles later.

Configuration
REQ-020 Macro AES256_KEY_CACHE_EN.
- Defined: LOAD compares `key` with the key of the last completed expansion. If equal and one expansion has completed since reset, EXPAND is skipped (period and latency 15 cycles). Otherwise behaviour is as REQ-011.
- Undefined: EXPAND always runs, and no cached-key comparison logic exists.

Structure
REQ-021 Package aes256_pkg SHALL hold:
- forward S-box (used by key expansion) and inverse S-box constant tables;
- the Rcon table;
- the FSM state enum;
- GF(2^8) xtime/multiply functions.
REQ-022 Sub-module aes256_inv_round SHALL be purely combinational: inputs 128-bit state, 128-bit round key, and a final-round flag; output is the next 128-bit state.

Verification
REQ-023 NIST SP800-38A F.1.6 vector: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, ciphertext f3eed1bdb5d2a03c064b5a7e3db181f8 -> `plaintext` 6bc1bee22e409f96e93d7e117393172a, 28 cycles after reset release.
REQ-024 FIPS-197 C.3 vector: key 000102...1e1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> `plaintext` 00112233445566778899aabbccddeeff.
REQ-025 Reset held low -> `plaintext`=0. Reset asserted at DECRYPT cycle 7 -> `plaintext`=0 immediately; the correct result appears 28 cycles after release.
REQ-026 Change `ciphertext` during EXPAND -> the current result uses the old block; the next period outputs the decryption of the new block.
REQ-027 With AES256_KEY_CACHE_EN and key held constant -> second and later results arrive 15 cycles apart. After a key change -> a 28-cycle period with correct output.
